// File: rtl/udp_sched_pkg.sv
// udp_sched_pkg: shared state encoding, default timeouts and helpers for the
// UDP transmit scheduler.
package udp_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        REQ,
        WAIT_RDY,
        XFER,
        GAP
    } sched_state_t;

    localparam int DEF_N_CH    = 4;
    localparam int DEF_IDLE_TO = 64;
    localparam int DEF_RDY_TO  = 16;
    localparam int GAP_CYCLES  = 4;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/udp_sched_rr_arb.sv
// udp_sched_rr_arb: combinational channel arbiter. Round-robin search starts
// at the channel after last_grant; prio_mode=1 selects lowest-index-wins.
module udp_sched_rr_arb #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0] req,
    input  logic [2:0]      last_grant,
    input  logic            prio_mode,
    output logic [2:0]      grant,
    output logic            valid
);

    logic [2*N_CH-1:0] req_dbl;
    logic [N_CH-1:0]   req_rot;
    logic [2:0]        rr_off;
    logic [2:0]        prio_idx;
    logic [3:0]        rr_sum;

    // Rotate the request vector so bit 0 is the channel right after last_grant
    assign req_dbl = {req, req};
    assign req_rot = N_CH'(req_dbl >> (4'(last_grant) + 4'd1));

    // Lowest set bit of the rotated and of the plain request vectors
    always_comb begin
        rr_off   = '0;
        prio_idx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (req_rot[k]) rr_off = 3'(k);
            if (req[k])     prio_idx = 3'(k);
        end
    end

    // Map the rotated offset back to an absolute channel index (mod N_CH)
    always_comb begin
        rr_sum = 4'(last_grant) + 4'd1 + 4'(rr_off);
        if (rr_sum >= 4'(N_CH)) rr_sum = rr_sum - 4'(N_CH);
    end

    assign grant = prio_mode ? prio_idx : rr_sum[2:0];
    assign valid = |req;

endmodule

// File: rtl/udp_tx_sched.sv
// udp_tx_sched: picks an eligible channel FIFO, requests a UDP packet from the
// transmitter and routes its word-read strobes to the granted FIFO.
// Build option: define UDP_TX_SCHED_PRIO_EN for fixed-priority arbitration
// (lowest eligible index wins); otherwise round-robin.
module udp_tx_sched
    import udp_sched_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int IDLE_TO = DEF_IDLE_TO,
    parameter int RDY_TO  = DEF_RDY_TO
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sched_en,
    input  logic [N_CH*16-1:0] ch_fifo_rdata,
    input  logic [N_CH*12-1:0] ch_fifo_cnt,
    output logic [N_CH-1:0]    ch_fifo_rd_en,
    input  logic [15:0]        cfg_src_port,
    input  logic [N_CH*16-1:0] cfg_dst_port,
    input  logic [N_CH*16-1:0] cfg_len,
    output logic               udp_tx_req,
    input  logic               udp_tx_ready,
    input  logic               tx_fifo_rd_en,
    output logic [15:0]        tx_fifo_data,
    output logic [15:0]        udp_src_port,
    output logic [15:0]        udp_dst_port,
    output logic [15:0]        udp_data_len,
    output logic               busy,
    output logic [2:0]         grant_id,
    output logic [15:0]        abort_cnt
);

`ifdef UDP_TX_SCHED_PRIO_EN
    localparam logic PRIO_MODE = 1'b1;
`else
    localparam logic PRIO_MODE = 1'b0;
`endif

    sched_state_t state;
    logic [2:0]   last_grant;
    logic [14:0]  word_cnt;
    logic [15:0]  timer;
    logic [N_CH-1:0] eligible;
    logic [2:0]   arb_grant;
    logic         arb_valid;

    // Channel views padded to 8 entries so the 3-bit grant indexes them directly
    logic [15:0] rdata_arr [8];
    logic [15:0] dst_arr   [8];
    logic [15:0] len_arr   [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pad
            if (gi < N_CH) begin : g_ch
                assign rdata_arr[gi] = ch_fifo_rdata[gi*16 +: 16];
                assign dst_arr[gi]   = cfg_dst_port[gi*16 +: 16];
                assign len_arr[gi]   = cfg_len[gi*16 +: 16];
                // Eligible once a whole packet (cfg_len/2 words) is buffered
                assign eligible[gi]  = {4'd0, ch_fifo_cnt[gi*12 +: 12]} >= {1'b0, cfg_len[gi*16+1 +: 15]};
                // Strobes pass only to the granted channel and only in XFER
                assign ch_fifo_rd_en[gi] = tx_fifo_rd_en && (state == XFER) && (grant_id == 3'(gi));
            end else begin : g_none
                assign rdata_arr[gi] = '0;
                assign dst_arr[gi]   = '0;
                assign len_arr[gi]   = '0;
            end
        end
    endgenerate

    assign tx_fifo_data = rdata_arr[grant_id];

    udp_sched_rr_arb #(.N_CH(N_CH)) u_arb (
        .req        (eligible),
        .last_grant (last_grant),
        .prio_mode  (PRIO_MODE),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    // Scheduler FSM; header fields and packet length are latched in ARB so
    // config changes mid-packet have no effect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 3'(N_CH - 1);
            grant_id     <= '0;
            udp_src_port <= '0;
            udp_dst_port <= '0;
            udp_data_len <= '0;
            word_cnt     <= '0;
            timer        <= '0;
            abort_cnt    <= '0;
            udp_tx_req   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sched_en && (|eligible)) begin
                        state <= ARB;
                        busy  <= 1'b1;
                    end
                end
                ARB: begin
                    if (arb_valid) begin
                        grant_id     <= arb_grant;
                        udp_src_port <= cfg_src_port;
                        udp_dst_port <= dst_arr[arb_grant];
                        udp_data_len <= len_arr[arb_grant];
                        word_cnt     <= '0;
                        udp_tx_req   <= 1'b1;
                        state        <= REQ;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                REQ: begin
                    udp_tx_req <= 1'b0;
                    timer      <= '0;
                    state      <= WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (udp_tx_ready) begin
                        timer <= '0;
                        state <= XFER;
                    end else if (timer == 16'(RDY_TO - 1)) begin
                        timer     <= '0;
                        abort_cnt <= sat_inc16(abort_cnt);
                        state     <= GAP;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                XFER: begin
                    if (tx_fifo_rd_en) begin
                        word_cnt <= word_cnt + 15'd1;
                        timer    <= '0;
                        if (word_cnt + 15'd1 == udp_data_len[15:1]) state <= GAP;
                    end else if (udp_tx_ready) begin
                        timer <= '0;
                    end else if (timer == 16'(IDLE_TO - 1)) begin
                        timer <= '0;
                        if (word_cnt < udp_data_len[15:1]) abort_cnt <= sat_inc16(abort_cnt);
                        state <= GAP;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                GAP: begin
                    if (timer == 16'(GAP_CYCLES - 1)) begin
                        timer      <= '0;
                        last_grant <= grant_id;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_sched.sv
// tb_udp_tx_sched: scenario tasks driving a transmitter model against the
// scheduler; expected packet headers are queued and popped on udp_tx_req.
module tb_udp_tx_sched;

    localparam int N_CH    = 4;
    localparam int IDLE_TO = 64;
    localparam int RDY_TO  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               sched_en;
    logic [N_CH*16-1:0] ch_fifo_rdata;
    logic [N_CH*12-1:0] ch_fifo_cnt;
    logic [N_CH-1:0]    ch_fifo_rd_en;
    logic [15:0]        cfg_src_port;
    logic [N_CH*16-1:0] cfg_dst_port;
    logic [N_CH*16-1:0] cfg_len;
    logic               udp_tx_req;
    logic               udp_tx_ready;
    logic               tx_fifo_rd_en;
    logic [15:0]        tx_fifo_data;
    logic [15:0]        udp_src_port;
    logic [15:0]        udp_dst_port;
    logic [15:0]        udp_data_len;
    logic               busy;
    logic [2:0]         grant_id;
    logic [15:0]        abort_cnt;

    udp_tx_sched #(.N_CH(N_CH), .IDLE_TO(IDLE_TO), .RDY_TO(RDY_TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sched_en      (sched_en),
        .ch_fifo_rdata (ch_fifo_rdata),
        .ch_fifo_cnt   (ch_fifo_cnt),
        .ch_fifo_rd_en (ch_fifo_rd_en),
        .cfg_src_port  (cfg_src_port),
        .cfg_dst_port  (cfg_dst_port),
        .cfg_len       (cfg_len),
        .udp_tx_req    (udp_tx_req),
        .udp_tx_ready  (udp_tx_ready),
        .tx_fifo_rd_en (tx_fifo_rd_en),
        .tx_fifo_data  (tx_fifo_data),
        .udp_src_port  (udp_src_port),
        .udp_dst_port  (udp_dst_port),
        .udp_data_len  (udp_data_len),
        .busy          (busy),
        .grant_id      (grant_id),
        .abort_cnt     (abort_cnt)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Channel FIFO model: word value = {channel, read pointer}
    int word_ptr [N_CH] = '{default: 0};
    int rd_cnt   [N_CH] = '{default: 0};
    int req_pulses = 0;

    always @(posedge clk) begin
        if (udp_tx_req) req_pulses <= req_pulses + 1;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_fifo_rd_en[i]) begin
                word_ptr[i] <= word_ptr[i] + 1;
                rd_cnt[i]   <= rd_cnt[i] + 1;
            end
        end
    end

    always_comb begin
        ch_fifo_rdata = '0;
        for (int i = 0; i < N_CH; i++)
            ch_fifo_rdata[i*16 +: 16] = 16'((i << 12) | (word_ptr[i] & 'hFFF));
    end

    typedef struct {
        int          ch;
        logic [15:0] dst;
        logic [15:0] len;
    } pkt_t;
    pkt_t exp_q [$];

    task automatic set_ch(input int i, input int cnt, input logic [15:0] dst, input logic [15:0] len);
        ch_fifo_cnt[i*12 +: 12]  = 12'(cnt);
        cfg_dst_port[i*16 +: 16] = dst;
        cfg_len[i*16 +: 16]      = len;
    endtask

    task automatic push_exp(input int ch, input logic [15:0] dst, input logic [15:0] len);
        pkt_t p;
        p.ch = ch; p.dst = dst; p.len = len;
        exp_q.push_back(p);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; sched_en = 1'b0; udp_tx_ready = 1'b0; tx_fifo_rd_en = 1'b0;
        ch_fifo_cnt = '0; cfg_dst_port = '0; cfg_len = {N_CH{16'd16}};
        cfg_src_port = 16'hC0DE;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Wait (bounded) for udp_tx_req, then pop and compare the expected header
    task automatic wait_req(output bit ok);
        pkt_t e;
        int n = 0;
        ok = 1'b0;
        while (!udp_tx_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (!udp_tx_req) begin
            tests_failed++;
            $display("FAIL req_timeout: udp_tx_req=0 after %0d cycles, required 1", n);
            return;
        end
        ok = 1'b1;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_req: grant_id=%0d, required no request", grant_id);
            return;
        end
        e = exp_q.pop_front();
        tests_run++;
        if (grant_id !== 3'(e.ch)) begin
            tests_failed++;
            $display("FAIL grant_id: got %0d, required %0d", grant_id, e.ch);
        end
        tests_run++;
        if (udp_dst_port !== e.dst) begin
            tests_failed++;
            $display("FAIL udp_dst_port: got %h, required %h", udp_dst_port, e.dst);
        end
        tests_run++;
        if (udp_data_len !== e.len) begin
            tests_failed++;
            $display("FAIL udp_data_len: got %0d, required %0d", udp_data_len, e.len);
        end
        tests_run++;
        if (udp_src_port !== 16'hC0DE) begin
            tests_failed++;
            $display("FAIL udp_src_port: got %h, required c0de", udp_src_port);
        end
        $display("[TB] request ch%0d dst=%h len=%0d", e.ch, e.dst, e.len);
    endtask

    // Transmitter model: ready after rdy_delay cycles, then nstr back-to-back strobes
    task automatic xfer(input int rdy_delay, input int nstr, input int ch);
        int base;
        logic [15:0] exp_word;
        base = word_ptr[ch];
        repeat (rdy_delay) @(negedge clk);
        udp_tx_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < nstr; k++) begin
            exp_word = 16'((ch << 12) | ((base + k) & 'hFFF));
            tests_run++;
            if (tx_fifo_data !== exp_word) begin
                tests_failed++;
                $display("FAIL tx_fifo_data: word %0d got %h, required %h", k, tx_fifo_data, exp_word);
            end
            tx_fifo_rd_en = 1'b1;
            #1;
            tests_run++;
            if (ch_fifo_rd_en !== N_CH'(1 << ch)) begin
                tests_failed++;
                $display("FAIL rd_en_route: got %b, required %b", ch_fifo_rd_en, N_CH'(1 << ch));
            end
            @(negedge clk);
        end
        tx_fifo_rd_en = 1'b0;
        udp_tx_ready  = 1'b0;
        $display("[TB] transfer ch%0d %0d words", ch, nstr);
    endtask

    // Count negedges (bounded) until busy drops
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (busy) begin
            tests_failed++;
            $display("FAIL idle_timeout: busy=1 after %0d cycles, required 0", n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sched_en = 1'b1; udp_tx_ready = 1'b1; tx_fifo_rd_en = 1'b1;
        ch_fifo_cnt = {N_CH{12'd100}}; cfg_dst_port = '1; cfg_len = {N_CH{16'd16}};
        cfg_src_port = 16'hC0DE;
        repeat (2) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || udp_tx_req !== 1'b0 || grant_id !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: busy=%b req=%b grant=%0d, required 0 0 0", busy, udp_tx_req, grant_id);
        end
        tests_run++;
        if (udp_src_port !== 16'd0 || udp_dst_port !== 16'd0 || udp_data_len !== 16'd0 || abort_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_fields: src=%h dst=%h len=%h abort=%h, required 0", udp_src_port, udp_dst_port, udp_data_len, abort_cnt);
        end
        tests_run++;
        if (ch_fifo_rd_en !== '0) begin
            tests_failed++;
            $display("FAIL reset_rd_en: got %b, required 0", ch_fifo_rd_en);
        end
        tests_run++;
        if (tx_fifo_data !== ch_fifo_rdata[15:0]) begin
            tests_failed++;
            $display("FAIL reset_data: got %h, required %h", tx_fifo_data, ch_fifo_rdata[15:0]);
        end
        $display("[TB] reset state checked");
    endtask

    task automatic test_basic();
        bit ok;
        int n, r0, r1, p0;
        do_reset();
        set_ch(0, 8, 16'h1234, 16'd16);
        r0 = rd_cnt[0]; r1 = rd_cnt[1] + rd_cnt[2] + rd_cnt[3]; p0 = req_pulses;
        push_exp(0, 16'h1234, 16'd16);
        sched_en = 1'b1;
        wait_req(ok);
        if (!ok) return;
        sched_en = 1'b0;
        xfer(3, 8, 0);
        wait_idle(n);
        tests_run++;
        if (n !== 4) begin
            tests_failed++;
            $display("FAIL gap_len: busy held %0d cycles after last strobe, required 4", n);
        end
        tests_run++;
        if (rd_cnt[0] - r0 !== 8 || rd_cnt[1] + rd_cnt[2] + rd_cnt[3] - r1 !== 0) begin
            tests_failed++;
            $display("FAIL basic_strobes: ch0 got %0d others %0d, required 8 and 0", rd_cnt[0] - r0, rd_cnt[1] + rd_cnt[2] + rd_cnt[3] - r1);
        end
        tests_run++;
        if (req_pulses - p0 !== 1 || abort_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL basic_req_abort: req pulses %0d abort %0d, required 1 and 0", req_pulses - p0, abort_cnt);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int n;
        int order [5];
`ifdef UDP_TX_SCHED_PRIO_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        do_reset();
        for (int i = 0; i < N_CH; i++) set_ch(i, 100, 16'(16'h5000 + i), 16'd4);
        for (int p = 0; p < 5; p++) push_exp(order[p], 16'(16'h5000 + order[p]), 16'd4);
        sched_en = 1'b1;
        for (int p = 0; p < 5; p++) begin
            wait_req(ok);
            if (!ok) break;
            if (p == 4) sched_en = 1'b0;
            xfer(1, 2, order[p]);
        end
        sched_en = 1'b0;
        wait_idle(n);
        exp_q.delete();
    endtask

    task automatic test_rdy_timeout();
        bit ok;
        int n, r0;
        do_reset();
        set_ch(0, 8, 16'h2222, 16'd16);
        r0 = rd_cnt[0];
        push_exp(0, 16'h2222, 16'd16);
        sched_en = 1'b1;
        wait_req(ok);
        if (!ok) return;
        sched_en = 1'b0;
        n = 0;
        while (abort_cnt == 16'd0 && n < 60) begin
            @(negedge clk);
            n++;
            if (n == 3) begin
                tx_fifo_rd_en = 1'b1;
                #1;
                tests_run++;
                if (ch_fifo_rd_en !== '0) begin
                    tests_failed++;
                    $display("FAIL stray_strobe: got %b in WAIT_RDY, required 0", ch_fifo_rd_en);
                end
                tx_fifo_rd_en = 1'b0;
            end
        end
        // Request cycle plus RDY_TO waiting cycles before GAP
        tests_run++;
        if (n !== RDY_TO + 1 || abort_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL rdy_timeout: abort=%0d after %0d cycles, required 1 after %0d", abort_cnt, n, RDY_TO + 1);
        end
        tests_run++;
        if (busy !== 1'b1 || rd_cnt[0] - r0 !== 0) begin
            tests_failed++;
            $display("FAIL rdy_gap: busy=%b strobes=%0d, required 1 and 0", busy, rd_cnt[0] - r0);
        end
        wait_idle(n);
        $display("[TB] ready timeout abort_cnt=%0d", abort_cnt);
    endtask

    task automatic test_idle_timeout();
        bit ok;
        int n, r0;
        do_reset();
        set_ch(0, 8, 16'h6666, 16'd16);
        r0 = rd_cnt[0];
        push_exp(0, 16'h6666, 16'd16);
        sched_en = 1'b1;
        wait_req(ok);
        if (!ok) return;
        sched_en = 1'b0;
        xfer(2, 3, 0);
        n = 0;
        while (abort_cnt == 16'd0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n !== IDLE_TO || abort_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL idle_exit: abort=%0d after %0d cycles, required 1 after %0d", abort_cnt, n, IDLE_TO);
        end
        tests_run++;
        if (rd_cnt[0] - r0 !== 3) begin
            tests_failed++;
            $display("FAIL idle_strobes: got %0d, required 3", rd_cnt[0] - r0);
        end
        wait_idle(n);
        $display("[TB] idle timeout abort_cnt=%0d", abort_cnt);
    endtask

    task automatic test_cfg_change();
        bit ok;
        int n, p0;
        do_reset();
        set_ch(1, 50, 16'h3333, 16'd16);
        push_exp(1, 16'h3333, 16'd16);
        p0 = req_pulses;
        sched_en = 1'b1;
        wait_req(ok);
        if (!ok) return;
        sched_en = 1'b0;
        cfg_len[16 +: 16] = 16'd40;
        @(negedge clk);
        tests_run++;
        if (udp_data_len !== 16'd16) begin
            tests_failed++;
            $display("FAIL len_hold: got %0d, required 16", udp_data_len);
        end
        xfer(1, 8, 1);
        tests_run++;
        if (udp_data_len !== 16'd16 || abort_cnt !== 16'd0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL cfg_change: len=%0d abort=%0d busy=%b, required 16 0 1", udp_data_len, abort_cnt, busy);
        end
        wait_idle(n);
        repeat (30) @(negedge clk);
        tests_run++;
        if (req_pulses - p0 !== 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL sched_off: req pulses %0d busy=%b, required 1 and 0", req_pulses - p0, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        do_reset();
        set_ch(2, 50, 16'h4444, 16'd16);
        push_exp(2, 16'h4444, 16'd16);
        sched_en = 1'b1;
        wait_req(ok);
        if (!ok) return;
        sched_en = 1'b0;
        @(negedge clk);
        udp_tx_ready = 1'b1;
        @(negedge clk);
        tx_fifo_rd_en = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if (ch_fifo_rd_en !== 4'b0100) begin
            tests_failed++;
            $display("FAIL mid_route: got %b, required 0100", ch_fifo_rd_en);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (ch_fifo_rd_en !== '0) begin
            tests_failed++;
            $display("FAIL reset_drop: got %b, required 0", ch_fifo_rd_en);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || udp_tx_req !== 1'b0 || grant_id !== 3'd0 || udp_data_len !== 16'd0 || udp_dst_port !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: busy=%b req=%b grant=%0d len=%0d dst=%h, required all 0", busy, udp_tx_req, grant_id, udp_data_len, udp_dst_port);
        end
        tx_fifo_rd_en = 1'b0;
        udp_tx_ready  = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N_CH; i++) set_ch(i, 100, 16'(16'h7000 + i), 16'd4);
        push_exp(0, 16'h7000, 16'd4);
        sched_en = 1'b1;
        wait_req(ok);
        sched_en = 1'b0;
        if (ok) xfer(1, 2, 0);
        wait_idle(n);
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_rdy_timeout();
        test_idle_timeout();
        test_cfg_change();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/udp_tx_sched.md
UDP_TX_SCHED -- requirements
Module: udp_tx_sched

Interface
REQ-001 Parameter N_CH, default 4, number of requesting channels (2..8).
REQ-002 Parameter IDLE_TO, default 64, cycles with no tx_fifo_rd_en before an active transfer is closed.
REQ-003 Parameter RDY_TO, default 16, cycles allowed from udp_tx_req to udp_tx_ready.
REQ-004 clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 sched_en  in  1  1 = arbitration enabled; 0 = finish current packet, then stay idle.
REQ-006 ch_fifo_rdata  in  N_CH*16  per-channel FIFO read data, slice i = channel i.
REQ-007 ch_fifo_cnt  in  N_CH*12  per-channel FIFO word count.
REQ-008 ch_fifo_rd_en  out  N_CH  per-channel FIFO read strobe.
REQ-009 cfg_src_port  in  16  common UDP source port.
REQ-010 cfg_dst_port  in  N_CH*16  per-channel destination port.
REQ-011 cfg_len  in  N_CH*16  per-channel payload bytes, even, >=2.
REQ-012 udp_tx_req  out  1  one-cycle packet request to the UDP transmitter.
REQ-013 udp_tx_ready  in  1  transmitter waiting for the lower layer.
REQ-014 tx_fifo_rd_en  in  1  transmitter word-read strobe.
REQ-015 tx_fifo_data  out  16  muxed read data of the granted channel.
REQ-016 udp_src_port, udp_dst_port, udp_data_len  out  16 each  header fields, held stable while busy.
REQ-017 busy  out  1; grant_id  out  3; abort_cnt  out  16  saturating abort count.

Function
REQ-018 The state machine SHALL use the states IDLE, ARB, REQ, WAIT_RDY, XFER and GAP.
REQ-019 IDLE: go to ARB when sched_en=1 and any channel is eligible (ch_fifo_cnt >= cfg_len/2).
REQ-020 ARB: use round-robin starting at (last grant + 1) mod N_CH; latch grant_id and the header fields; go to REQ.
REQ-021 REQ: assert udp_tx_req for exactly one cycle; go to WAIT_RDY.
REQ-022 WAIT_RDY: go to XFER when udp_tx_ready=1; after RDY_TO cycles without it, increment abort_cnt and go to GAP.
REQ-023 XFER: route tx_fifo_rd_en to ch_fifo_rd_en[grant_id] combinationally, zero latency; all other strobes stay 0.
REQ-024 XFER: count words on tx_fifo_rd_en; go to GAP when count = cfg_len/2, or after IDLE_TO cycles with udp_tx_ready=0 and no strobe.
REQ-025 XFER: if the IDLE_TO exit is taken with count < cfg_len/2, increment abort_cnt.
REQ-026 GAP: hold 4 cycles, then go to IDLE; last grant updates only here.
REQ-027 tx_fifo_data SHALL equal the ch_fifo_rdata slice of grant_id in every state.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 Strobes seen outside XFER SHALL be dropped and not routed.
REQ-030 A change of cfg_* or sched_en while busy SHALL not affect the current packet.
REQ-031 abort_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-032 On rst_n low: state IDLE, last grant N_CH-1 (first grant = channel 0), all outputs 0, word counter 0.
REQ-033 Reset mid-transfer SHALL drop all strobes immediately; no recovery of the packet.

Configuration
REQ-034 UDP_TX_SCHED_PRIO_EN defined: ARB SHALL use fixed priority, lowest eligible index wins.
REQ-035 UDP_TX_SCHED_PRIO_EN undefined: ARB SHALL use round-robin as in REQ-020.

Structure
REQ-036 Package udp_sched_pkg SHALL hold the state encoding and default timeout constants.
REQ-037 Arbitration SHALL sit in sub-module udp_sched_rr_arb (request vector, last grant, and priority mode -> grant index and valid).

Verification
REQ-038 Ch0 at cnt=8, cfg_len=16, ready after 3 cycles, 8 strobes -> one udp_tx_req, ch_fifo_rd_en[0] pulses 8 times, abort_cnt=0, busy low 4 cycles after the last strobe.
REQ-039 All four channels always eligible -> grants 0,1,2,3,0 in round-robin; with UDP_TX_SCHED_PRIO_EN -> 0,0,0.
REQ-040 udp_tx_ready never asserts -> GAP entered at RDY_TO=16 cycles after the request, abort_cnt=1.
REQ-041 Ready asserts, only 3 of 8 strobes arrive -> exit after 64 idle cycles, abort_cnt=1.
REQ-042 cfg_len[1] changed and sched_en=0 during ch1 transfer -> udp_data_len unchanged, no new request.
REQ-043 rst_n low mid-XFER -> all outputs 0 next edge, first grant after reset is ch0.
